// File: rtl/fixed_point_multiplier.sv
// fixed_point_multiplier: sequential signed fixed-point multiplier, radix-2 shift-add on magnitudes, one bit per clock.
// Define FIXED_POINT_MULT_SATURATE_EN to saturate the result on overflow instead of wrapping.
module fixed_point_multiplier #(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic             overflow_flag,
  output logic             finish
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int QW = 2 * WIDTH - FRAC_BITS;
  localparam logic [QW-1:0] POS_MAX = QW'((64'd1 << (WIDTH - 1)) - 64'd1);
  localparam logic [QW-1:0] NEG_MAX = QW'(64'd1 << (WIDTH - 1));
  typedef enum logic [1:0] {IDLE, BUSY, FINAL, DONE} state_t;
  state_t state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d;
  logic [WIDTH-1:0] mplier_q, mplier_d, result_q, result_d;
  logic sign_q, sign_d, ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] abs_a, abs_b, q_lo, wrap, res;
  logic [QW-1:0] q;
  logic neg, ovf;
  assign abs_a = A[WIDTH-1] ? -A : A;
  assign abs_b = B[WIDTH-1] ? -B : B;
  assign q     = acc_q[2*WIDTH-1:FRAC_BITS];
  // a zero quotient is always reported positive so no negative zero appears
  assign neg   = sign_q && (q != '0);
  assign ovf   = neg ? (q > NEG_MAX) : (q > POS_MAX);
  assign q_lo  = q[WIDTH-1:0];
  assign wrap  = neg ? -q_lo : q_lo;
`ifdef FIXED_POINT_MULT_SATURATE_EN
  assign res = ovf ? (neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) : wrap;
`else
  assign res = wrap;
`endif
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    sign_d   = sign_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        mcand_d  = {{WIDTH{1'b0}}, abs_a};
        mplier_d = abs_b;
        sign_d   = A[WIDTH-1] ^ B[WIDTH-1];
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = BUSY;
      end
      BUSY: if (cnt_q == CW'(WIDTH)) state_d = FINAL;
      else begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
      end
      FINAL: begin
        result_d = res;
        ovf_d    = ovf;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      sign_q   <= sign_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end
  assign result        = result_q;
  assign overflow_flag = ovf_q;
  assign finish        = (state_q == DONE);
endmodule
